// File: rtl/ldpc_iter_sched.sv
// LDPC iteration scheduler: loads a frame into the message RAM, sequences the
// per-column decode phases, and runs a syndrome check after the load and after
// every pass until a zero syndrome, MAX_ITER passes, or abort.
module ldpc_iter_sched #(
  parameter int N_COLS   = 21,
  parameter int ADDR_W   = 5,
  parameter int MAX_ITER = 20,
  parameter int ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              chk_valid,
  input  logic              ok_n,
  output logic              sel_load,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              stb_expand,
  output logic              stb_add,
  output logic              stb_min,
  output logic              stb_compress,
  output logic              stb_check,
  output logic              stb_update,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              success
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(N_COLS - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_RD       = 4'd2,
    S_EXP      = 4'd3,
    S_ADD      = 4'd4,
    S_MIN      = 4'd5,
    S_WR       = 4'd6,
    S_CMP      = 4'd7,
    S_CHK_REQ  = 4'd8,
    S_CHK_WAIT = 4'd9,
    S_DONE     = 4'd10
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              abort_act;
  logic              accept;

  // Phase strobes decoded from the state; abort suppresses every strobe and the load handshake.
  always_comb begin
    abort_act    = abort && (state != S_IDLE) && (state != S_DONE);
    accept       = 1'b0;
    in_ready     = 1'b0;
    sel_load     = 1'b0;
    we           = 1'b0;
    re           = 1'b0;
    stb_expand   = 1'b0;
    stb_add      = 1'b0;
    stb_min      = 1'b0;
    stb_compress = 1'b0;
    stb_check    = 1'b0;
    stb_update   = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_LOAD: begin
        sel_load     = 1'b1;
        in_ready     = !abort_act;
        accept       = in_valid && !abort_act;
        we           = accept;
        stb_compress = accept;
      end
      S_RD:       re           = !abort_act;
      S_EXP:      stb_expand   = !abort_act;
      S_ADD:      stb_add      = !abort_act;
      S_MIN:      stb_min      = !abort_act;
      S_WR:       we           = !abort_act;
      S_CMP:      stb_compress = !abort_act;
      S_CHK_REQ:  stb_check    = !abort_act;
      S_CHK_WAIT: stb_update   = !abort_act && chk_valid && ok_n && (iter != ITER_MAX);
      default:    busy         = (state != S_IDLE);
    endcase
    // Addresses follow the column only while their strobe is active, otherwise hold.
    if (we) begin
      waddr = col;
    end else begin
      waddr = waddr_q;
    end
    if (re) begin
      raddr = col;
    end else begin
      raddr = raddr_q;
    end
  end

  // State sequencing, column/iteration counters, status flags and held addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      col     <= '0;
      iter    <= '0;
      success <= 1'b0;
      done    <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
    end else begin
      done <= (state == S_DONE);
      if (we) begin
        waddr_q <= col;
      end
      if (re) begin
        raddr_q <= col;
      end
      if (abort_act) begin
        state   <= S_DONE;
        success <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              iter    <= '0;
              success <= 1'b0;
              col     <= '0;
              state   <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (accept) begin
              if (col == LAST_COL) begin
                col   <= '0;
                state <= S_CHK_REQ;
              end else begin
                col <= col + ADDR_W'(1);
              end
            end
          end
          S_RD:  state <= S_EXP;
          S_EXP: state <= S_ADD;
          S_ADD: state <= S_MIN;
          S_MIN: state <= S_WR;
          S_WR:  state <= S_CMP;
          S_CMP: begin
            if (col == LAST_COL) begin
              col   <= '0;
              state <= S_CHK_REQ;
            end else begin
              col   <= col + ADDR_W'(1);
              state <= S_RD;
            end
          end
          S_CHK_REQ: state <= S_CHK_WAIT;
          S_CHK_WAIT: begin
            if (chk_valid) begin
              if (!ok_n) begin
                success <= 1'b1;
                state   <= S_DONE;
              end else if (iter == ITER_MAX) begin
                state <= S_DONE;
              end else begin
                iter  <= iter + ITER_W'(1);
                state <= S_RD;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
